dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single data memory (`DataMem`) between the core's load/store path and a debug/loader port. Use it for program/data preload and run-time inspection without a second memory port. It sits between the core datapath (ALU address, rs2 store data, writeback load data) and `DataMem`. Each access is sequenced through a small FSM with a req/ack handshake and round-robin tie-breaking. It produces a stall for the core while the core's access is pending.

## Interface
- `AW`, 32, address width (byte address, passed unchanged to memory)
- `DW`, 32, data width
- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `core_req`  in  1  core access request, held until `core_ack`
- `core_we`  in  1  1 = store, 0 = load
- `core_addr`  in  AW  core address (ALU result)
- `core_wdata`  in  DW  core store data
- `core_rdata`  out  DW  registered load data, valid while `core_ack`=1
- `core_ack`  out  1  one-cycle completion pulse
- `core_stall`  out  1  `core_req & ~core_ack`, combinational; freezes PC/regfile write
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_rdata`, `dbg_ack`  same as the core_* signals, for the debug/loader port
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, combinational from `mem_addr`

## Operation
- FSM states: IDLE, SERVE_CORE, SERVE_DBG, RESP.
- IDLE:
  - Neither request active: stay in IDLE.
  - Exactly one request active: go to SERVE for that port.
  - Both requests active: grant the port that was NOT granted last (`last_gnt`).
  - The winner's `we`/`addr`/`wdata` are latched into a request register on the transition edge.
- SERVE_x:
  - `mem_addr` = latched addr.
  - `mem_wdata` = latched wdata.
  - `mem_we` = latched we.
  - At the closing edge: `mem_rdata` is captured into that port's rdata register (also on writes; value unspecified for writes), `last_gnt` is set to x, and the FSM goes to RESP.
- RESP:
  - The ack for the served port is 1.
  - No arbitration happens in this state, so a requester still holding req during its ack cycle is not re-accepted.
  - Next state is IDLE.
- Outside SERVE: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Rdata registers hold their value until the next access completes on that port.
- A request dropped before it is granted is simply not served. A request dropped after it is latched still completes, and the ack is still pulsed.
- Requesters must not change `we`/`addr`/`wdata` while req is high and ack has not yet been seen; the arbiter samples them only at the IDLE→SERVE edge.

## Timing
- Reset values:
  - State = IDLE.
  - `last_gnt` = dbg, so the core wins the first tie.
  - `core_ack` = `dbg_ack` = 0.
  - `core_rdata` = `dbg_rdata` = 0.
  - `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- `rst` high in any cycle forces `mem_we`=0 combinationally in that cycle. An access in SERVE at that time is discarded (no write commit, no ack). Next state is IDLE.
- Latency: req sampled high in IDLE at edge E0 → SERVE during cycle E0..E1 → ack high during E1..E2.
  - With the memory in IDLE, the access takes 3 cycles from request to ack.
  - One access completes every 3 cycles at most.
- Back-to-back contention: the core and dbg requests alternate (core, dbg, core, ...). No port waits more than one other access.
- A single requester that re-asserts immediately after its ack is served again after one IDLE cycle.
- `core_stall` is combinational. It deasserts in the same cycle that `core_ack`=1.

## Test plan
- Reset: hold `rst` for 2 cycles with both requests high. Required: all outputs 0 during reset. The first grant after release goes to the core (`mem_addr` = `core_addr` in the first SERVE cycle).
- Core store then load: store 0xDEADBEEF to 0x10, then load 0x10. Required: `mem_we`=1 for exactly one cycle; `core_ack` 2 cycles after sampling; `core_rdata`=0xDEADBEEF at the second ack; `core_stall` high exactly until each ack.
- Simultaneous requests held: core addr 0x20 and dbg addr 0x40, 4 accesses. Required: memory address sequence 0x20, 0x40, 0x20, 0x40; one ack every 3 cycles, alternating ports.
- Debug preload during a stall: dbg writes 0x00000005 to 0x8 while the core load of 0x8 is pending. Dbg wins the tie if `last_gnt`=core. Required: `core_rdata`=5.
- Reset mid-access: assert `rst` during SERVE of a core store of 0x1234 to 0x4. Required: no write occurs (a later load of 0x4 returns the old value), no `core_ack`, state IDLE after reset.
- Held req across ack: keep `dbg_req` high through RESP. Required: exactly one additional access, starting 1 cycle after RESP, and no double ack.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for one data-memory port: req/ack handshake plus access payload.
// The requester uses the master modport; the arbiter uses the slave modport.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one combinational-read data memory between the core load/store path and a
// debug/loader port: IDLE -> SERVE_x (memory driven) -> RESP (ack pulse), round-robin on ties.
module dmem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave core,
  dmem_arbiter_if.slave dbg,
  output logic          core_stall,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, SERVE_CORE, SERVE_DBG, RESP} state_e;

  localparam logic GNT_CORE = 1'b0;
  localparam logic GNT_DBG  = 1'b1;

  state_e        state_q,      state_d;
  logic          last_gnt_q,   last_gnt_d;
  logic          req_we_q,     req_we_d;
  logic [AW-1:0] req_addr_q,   req_addr_d;
  logic [DW-1:0] req_wdata_q,  req_wdata_d;
  logic          core_ack_q,   core_ack_d;
  logic          dbg_ack_q,    dbg_ack_d;
  logic [DW-1:0] core_rdata_q, core_rdata_d;
  logic [DW-1:0] dbg_rdata_q,  dbg_rdata_d;
  logic          grant_core;
  logic          grant_dbg;

  // Request register doubles as the memory drive: it is nonzero only while in SERVE.
  always_comb begin
    state_d      = state_q;
    last_gnt_d   = last_gnt_q;
    req_we_d     = 1'b0;
    req_addr_d   = '0;
    req_wdata_d  = '0;
    core_ack_d   = 1'b0;
    dbg_ack_d    = 1'b0;
    core_rdata_d = core_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    grant_core   = 1'b0;
    grant_dbg    = 1'b0;

    unique case (state_q)
      IDLE: begin
        grant_core = core.req & (~dbg.req | (last_gnt_q == GNT_DBG));
        grant_dbg  = dbg.req & ~grant_core;
        if (grant_core) begin
          state_d     = SERVE_CORE;
          req_we_d    = core.we;
          req_addr_d  = core.addr;
          req_wdata_d = core.wdata;
        end else if (grant_dbg) begin
          state_d     = SERVE_DBG;
          req_we_d    = dbg.we;
          req_addr_d  = dbg.addr;
          req_wdata_d = dbg.wdata;
        end
      end
      SERVE_CORE: begin
        core_rdata_d = mem_rdata;
        core_ack_d   = 1'b1;
        last_gnt_d   = GNT_CORE;
        state_d      = RESP;
      end
      SERVE_DBG: begin
        dbg_rdata_d = mem_rdata;
        dbg_ack_d   = 1'b1;
        last_gnt_d  = GNT_DBG;
        state_d     = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_gnt_q   <= GNT_DBG;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      core_ack_q   <= 1'b0;
      dbg_ack_q    <= 1'b0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      core_ack_q   <= core_ack_d;
      dbg_ack_q    <= dbg_ack_d;
      core_rdata_q <= core_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // Reset blocks the write of an in-flight store in the very cycle it is raised.
  assign mem_we     = req_we_q & ~rst;
  assign mem_addr   = req_addr_q;
  assign mem_wdata  = req_wdata_q;

  assign core.ack   = core_ack_q;
  assign core.rdata = core_rdata_q;
  assign dbg.ack    = dbg_ack_q;
  assign dbg.rdata  = dbg_rdata_q;
  assign core_stall = core.req & ~core_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table-driven single accesses plus hand-written
// contention/reset/hold sequences, with an ack-ordered scoreboard of expected accesses.
module tb_dmem_arbiter;

  typedef struct packed {
    logic        port;   // 0 = core, 1 = dbg
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;  // expected load data (ignored for stores)
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_stall;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  dmem_arbiter_if #(.AW(32), .DW(32)) core_if ();
  dmem_arbiter_if #(.AW(32), .DW(32)) dbg_if ();

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .core       (core_if),
    .dbg        (dbg_if),
    .core_stall (core_stall),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten words read back as 0xA0000000 | word index.
  logic [31:0] mem_arr [256];
  bit   [255:0] written;
  logic [7:0]  ridx;
  assign ridx      = mem_addr[9:2];
  assign mem_rdata = written[ridx] ? mem_arr[ridx] : (32'hA000_0000 | 32'(ridx));

  always @(posedge clk) begin
    if (mem_we) begin
      mem_arr[mem_addr[9:2]] <= mem_wdata;
      written[mem_addr[9:2]] <= 1'b1;
    end
  end

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          we_cnt = 0;
  logic [31:0] prev_addr = '0;
  logic        prev_we   = 1'b0;
  vec_t        sb_q [$];
  vec_t        vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and score any ack seen there.
  task automatic tick();
    vec_t e;
    @(negedge clk);
    cyc++;
    if (mem_we) we_cnt++;
    if (!rst && (core_if.ack || dbg_if.ack)) begin
      chk("dual_ack", 32'(core_if.ack & dbg_if.ack), 32'd0);
      chk("ack_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("ack_port", 32'(dbg_if.ack), 32'(e.port));
        chk("serve_addr", prev_addr, e.addr);
        chk("serve_we", 32'(prev_we), 32'(e.we));
        if (!e.we) chk("rdata", e.port ? dbg_if.rdata : core_if.rdata, e.rdata);
      end
    end
    prev_addr = mem_addr;
    prev_we   = mem_we;
  endtask

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      dbg_if.req = req; dbg_if.we = we; dbg_if.addr = addr; dbg_if.wdata = wdata;
    end else begin
      core_if.req = req; core_if.we = we; core_if.addr = addr; core_if.wdata = wdata;
    end
  endtask

  task automatic wait_ack(input logic port, input int maxc, output int n);
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < maxc) begin
      tick();
      n++;
      seen = port ? dbg_if.ack : core_if.ack;
    end
    chk("ack_seen", 32'(seen), 32'd1);
  endtask

  // One isolated access on an idle arbiter, checking latency, stall and write count.
  task automatic do_access(input vec_t v);
    int n;
    int w0;
    w0 = we_cnt;
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    sb_q.push_back(v);
    #1;
    if (!v.port) chk("stall_pending", 32'(core_stall), 32'd1);
    wait_ack(v.port, 8, n);
    chk("ack_latency", 32'(n), 32'd2);
    if (!v.port) chk("stall_at_ack", 32'(core_stall), 32'd0);
    chk("we_cycles", 32'(we_cnt - w0), 32'(v.we));
    drive(v.port, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
  endtask

  initial begin
    int n;
    int acks;
    int t [4];

    // Table of isolated accesses: {port, we, addr, wdata, expected rdata}
    vecs[0] = '{1'b0, 1'b1, 32'h10,  32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h10,  32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b1, 32'h20,  32'h1111_2222, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h20,  32'h0,         32'h1111_2222};
    vecs[4] = '{1'b0, 1'b0, 32'h20,  32'h0,         32'h1111_2222};
    vecs[5] = '{1'b1, 1'b0, 32'h10,  32'h0,         32'hDEAD_BEEF};
    vecs[6] = '{1'b0, 1'b0, 32'h30,  32'h0,         32'hA000_000C};
    vecs[7] = '{1'b1, 1'b1, 32'h3FC, 32'hFFFF_FFFF, 32'h0};
    vecs[8] = '{1'b0, 1'b0, 32'h3FC, 32'h0,         32'hFFFF_FFFF};

    // Reset held two cycles with both requests pending
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h44, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h48, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_acks", 32'({core_if.ack, dbg_if.ack}), 32'd0);
      chk("rst_core_rdata", core_if.rdata, 32'd0);
      chk("rst_dbg_rdata", dbg_if.rdata, 32'd0);
    end
    sb_q.push_back('{1'b0, 1'b0, 32'h44, 32'h0, 32'hA000_0011});
    sb_q.push_back('{1'b1, 1'b0, 32'h48, 32'h0, 32'hA000_0012});
    rst = 1'b0;
    tick();
    chk("first_grant_core", mem_addr, 32'h44);
    wait_ack(1'b0, 4, n);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_ack(1'b1, 8, n);
    chk("dbg_after_core_lat", 32'(n), 32'd3);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();

    // Both ports held: alternate core/dbg, one ack every 3 cycles
    for (int k = 0; k < 2; k++) begin
      sb_q.push_back('{1'b0, 1'b0, 32'h20, 32'h0, 32'hA000_0008});
      sb_q.push_back('{1'b1, 1'b0, 32'h40, 32'h0, 32'hA000_0010});
    end
    drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    acks = 0;
    for (int k = 0; k < 20 && acks < 4; k++) begin
      tick();
      if (core_if.ack || dbg_if.ack) begin
        t[acks] = cyc;
        acks++;
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("contention_acks", 32'(acks), 32'd4);
    for (int i = 1; i < 4; i++) chk("contention_gap", 32'(t[i] - t[i-1]), 32'd3);
    tick();

    // Table-driven isolated accesses
    foreach (vecs[i]) do_access(vecs[i]);

    // Debug preload wins the tie when the core was granted last
    do_access('{1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF});
    sb_q.push_back('{1'b1, 1'b1, 32'h8, 32'h5, 32'h0});
    sb_q.push_back('{1'b0, 1'b0, 32'h8, 32'h0, 32'h5});
    drive(1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 32'h8, 32'h5);
    acks = 0;
    for (int k = 0; k < 12 && acks == 0; k++) begin
      tick();
      if (dbg_if.ack) drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      if (core_if.ack) begin
        chk("preload_core_rdata", core_if.rdata, 32'h5);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        acks = 1;
      end
    end
    chk("preload_core_done", 32'(acks), 32'd1);
    tick();

    // Reset during SERVE of a core store: no write, no ack
    drive(1'b0, 1'b1, 1'b1, 32'h4, 32'h1234);
    tick();
    chk("abort_serve_we", 32'(mem_we), 32'd1);
    chk("abort_serve_addr", mem_addr, 32'h4);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    chk("abort_ack", 32'(core_if.ack), 32'd0);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_core_rdata", core_if.rdata, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_ack", 32'(core_if.ack), 32'd0);
    end
    do_access('{1'b0, 1'b0, 32'h4, 32'h0, 32'hA000_0001});

    // dbg_req held through RESP: one extra access, one IDLE cycle later, no double ack
    sb_q.push_back('{1'b1, 1'b0, 32'h20, 32'h0, 32'h1111_2222});
    sb_q.push_back('{1'b1, 1'b0, 32'h20, 32'h0, 32'h1111_2222});
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    wait_ack(1'b1, 8, n);
    chk("hold_first_lat", 32'(n), 32'd2);
    tick();
    chk("hold_idle_no_ack", 32'(dbg_if.ack), 32'd0);
    tick();
    chk("hold_reserve_addr", mem_addr, 32'h20);
    tick();
    chk("hold_second_ack", 32'(dbg_if.ack), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_no_extra_ack", 32'(dbg_if.ack), 32'd0);
    end

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
